// File: rtl/fp_pkg.sv
// Shared constants, FSM encoding and field helpers for FP operand alignment.
package fp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMP   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } align_st_e;

  localparam int          FRAC_W     = 23;
  localparam int          EXP_W      = 8;
  localparam int          MAN_W      = 32;
  localparam int          HIDDEN_BIT = 31;
  localparam int          GUARD_PAD  = 8;
  localparam logic [7:0]  EXP_ZERO   = 8'd0;
  localparam logic [7:0]  EXP_MAX    = 8'd255;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  // Denormals share the exponent of the smallest normal but lack the hidden bit.
  function automatic logic [7:0] eff_exp(input logic [7:0] e);
    return (e == EXP_ZERO) ? 8'd1 : e;
  endfunction

  function automatic logic [MAN_W-1:0] mantissa(input logic [7:0] e, input logic [22:0] frac);
    logic [MAN_W-1:0] m;
    m = '0;
    m[HIDDEN_BIT] = (e != EXP_ZERO);
    m[HIDDEN_BIT-1 -: FRAC_W] = frac;
    return m;
  endfunction

endpackage

// File: rtl/shift_right.sv
// Logical right barrel shifter.
module SHIFT_RIGHT #(
  parameter int DATA_WIDTH   = 32,
  parameter int SELECT_WIDTH = 5
) (
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [SELECT_WIDTH-1:0] shift_num,
  output logic [DATA_WIDTH-1:0]   data_out
);

  assign data_out = data_in >> shift_num;

endmodule

// File: rtl/fp_align_ctrl.sv
// Orders two single-precision operands by magnitude and aligns the smaller
// mantissa to the larger exponent, one operation per four cycles.
module fp_align_ctrl
  import fp_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int SELECT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            exp_out,
  output logic [DATA_WIDTH-1:0] man_big,
  output logic [DATA_WIDTH-1:0] man_small,
  output logic                  sign_big,
  output logic                  sign_small,
  output logic                  swap,
  output logic                  sticky,
  output logic                  special
);

  localparam logic [7:0] SHIFT_LIMIT = 8'(DATA_WIDTH - 1);

  align_st_e             state_q, state_d;
  fp32_t                 a_q, a_d, b_q, b_d;
  logic [7:0]            exp_big_q, exp_big_d, diff_q, diff_d;
  logic [DATA_WIDTH-1:0] man_b_q, man_b_d, man_s_q, man_s_d;
  logic                  sgn_b_q, sgn_b_d, sgn_s_q, sgn_s_d;
  logic                  swp_q, swp_d, spc_q, spc_d;

  logic                  in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [7:0]            exp_out_q, exp_out_d;
  logic [DATA_WIDTH-1:0] man_big_q, man_big_d, man_small_q, man_small_d;
  logic                  sign_big_q, sign_big_d, sign_small_q, sign_small_d;
  logic                  swap_q, swap_d, sticky_q, sticky_d, special_q, special_d;

  logic [7:0]            ea, eb;
  logic [DATA_WIDTH-1:0] ma, mb, shifted, lost_mask;
  logic                  b_larger, far;

  assign ea = eff_exp(a_q.exp);
  assign eb = eff_exp(b_q.exp);
  assign ma = mantissa(a_q.exp, a_q.frac);
  assign mb = mantissa(b_q.exp, b_q.frac);
  // Strictly greater so that equal magnitudes keep a as the big operand.
  assign b_larger = {eb, b_q.frac} > {ea, a_q.frac};

  SHIFT_RIGHT #(
    .DATA_WIDTH   (DATA_WIDTH),
    .SELECT_WIDTH (SELECT_WIDTH)
  ) u_shift (
    .data_in   (man_s_q),
    .shift_num (diff_q[SELECT_WIDTH-1:0]),
    .data_out  (shifted)
  );

  assign far       = diff_q > SHIFT_LIMIT;
  assign lost_mask = ~({DATA_WIDTH{1'b1}} << diff_q[SELECT_WIDTH-1:0]);

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    exp_big_d    = exp_big_q;
    diff_d       = diff_q;
    man_b_d      = man_b_q;
    man_s_d      = man_s_q;
    sgn_b_d      = sgn_b_q;
    sgn_s_d      = sgn_s_q;
    swp_d        = swp_q;
    spc_d        = spc_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    exp_out_d    = exp_out_q;
    man_big_d    = man_big_q;
    man_small_d  = man_small_q;
    sign_big_d   = sign_big_q;
    sign_small_d = sign_small_q;
    swap_d       = swap_q;
    sticky_d     = sticky_q;
    special_d    = special_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d        = fp32_t'(a[31:0]);
          b_d        = fp32_t'(b[31:0]);
          in_ready_d = 1'b0;
          state_d    = ST_CMP;
        end
      end
      ST_CMP: begin
        swp_d     = b_larger;
        exp_big_d = b_larger ? eb : ea;
        diff_d    = b_larger ? (eb - ea) : (ea - eb);
        man_b_d   = b_larger ? mb : ma;
        man_s_d   = b_larger ? ma : mb;
        sgn_b_d   = b_larger ? b_q.sign : a_q.sign;
        sgn_s_d   = b_larger ? a_q.sign : b_q.sign;
        spc_d     = (a_q.exp == EXP_MAX) || (b_q.exp == EXP_MAX);
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        exp_out_d    = exp_big_q;
        man_big_d    = man_b_q;
        man_small_d  = far ? '0 : shifted;
        sticky_d     = far ? (|man_s_q) : (|(man_s_q & lost_mask));
        sign_big_d   = sgn_b_q;
        sign_small_d = sgn_s_q;
        swap_d       = swp_q;
        special_d    = spc_q;
        out_valid_d  = 1'b1;
        state_d      = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      exp_big_q    <= '0;
      diff_q       <= '0;
      man_b_q      <= '0;
      man_s_q      <= '0;
      sgn_b_q      <= 1'b0;
      sgn_s_q      <= 1'b0;
      swp_q        <= 1'b0;
      spc_q        <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      exp_out_q    <= '0;
      man_big_q    <= '0;
      man_small_q  <= '0;
      sign_big_q   <= 1'b0;
      sign_small_q <= 1'b0;
      swap_q       <= 1'b0;
      sticky_q     <= 1'b0;
      special_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      exp_big_q    <= exp_big_d;
      diff_q       <= diff_d;
      man_b_q      <= man_b_d;
      man_s_q      <= man_s_d;
      sgn_b_q      <= sgn_b_d;
      sgn_s_q      <= sgn_s_d;
      swp_q        <= swp_d;
      spc_q        <= spc_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      exp_out_q    <= exp_out_d;
      man_big_q    <= man_big_d;
      man_small_q  <= man_small_d;
      sign_big_q   <= sign_big_d;
      sign_small_q <= sign_small_d;
      swap_q       <= swap_d;
      sticky_q     <= sticky_d;
      special_q    <= special_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign exp_out    = exp_out_q;
  assign man_big    = man_big_q;
  assign man_small  = man_small_q;
  assign sign_big   = sign_big_q;
  assign sign_small = sign_small_q;
  assign swap       = swap_q;
  assign sticky     = sticky_q;
  assign special    = special_q;

endmodule

// File: tb/tb_fp_align_ctrl.sv
// Directed and random bench for fp_align_ctrl with a result scoreboard.
module tb_fp_align_ctrl;

  typedef struct packed {
    logic [7:0]  exp_out;
    logic [31:0] man_big;
    logic [31:0] man_small;
    logic        sign_big;
    logic        sign_small;
    logic        swap;
    logic        sticky;
    logic        special;
  } res_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [31:0] a, b;
  logic        in_ready, out_valid;
  logic [7:0]  exp_out;
  logic [31:0] man_big, man_small;
  logic        sign_big, sign_small, swap, sticky, special;

  int   n_cmp  = 0;
  int   n_fail = 0;
  res_t sb[$];

  fp_align_ctrl #(.DATA_WIDTH(32), .SELECT_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .exp_out(exp_out), .man_big(man_big), .man_small(man_small),
    .sign_big(sign_big), .sign_small(sign_small), .swap(swap),
    .sticky(sticky), .special(special)
  );

  always #5 clk = ~clk;

  function automatic res_t observed();
    return '{exp_out, man_big, man_small, sign_big, sign_small, swap, sticky, special};
  endfunction

  // Reference: compare magnitudes as integers, align through a 64-bit window.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y);
    res_t        r;
    logic [7:0]  ex, ey, eb, es;
    logic [31:0] mx, my, ms;
    logic [63:0] win;
    int          d;
    logic        y_big;
    ex = (x[30:23] == 0) ? 8'd1 : x[30:23];
    ey = (y[30:23] == 0) ? 8'd1 : y[30:23];
    mx = {x[30:23] != 0, x[22:0], 8'h00};
    my = {y[30:23] != 0, y[22:0], 8'h00};
    y_big = (int'(ey) * 8388608 + int'(y[22:0])) > (int'(ex) * 8388608 + int'(x[22:0]));
    eb = y_big ? ey : ex;
    es = y_big ? ex : ey;
    ms = y_big ? mx : my;
    d  = int'(eb) - int'(es);
    r.exp_out    = eb;
    r.man_big    = y_big ? my : mx;
    r.sign_big   = y_big ? y[31] : x[31];
    r.sign_small = y_big ? x[31] : y[31];
    r.swap       = y_big;
    r.special    = (x[30:23] == 8'hFF) || (y[30:23] == 8'hFF);
    if (d > 31) begin
      r.man_small = 32'h0;
      r.sticky    = |ms;
    end else begin
      win = {ms, 32'h0} >> d;
      r.man_small = win[63:32];
      r.sticky    = |win[31:0];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction; stall_n cycles with out_ready low while holding.
  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input res_t e, input int stall_n);
    res_t want;
    chk({tag, " in_ready idle"}, 128'(in_ready), 128'(1));
    a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    // Junk offered while busy must be ignored.
    a = 32'hDEADBEEF; b = 32'h7FC00001;
    chk({tag, " ovalid cmp"}, 128'(out_valid), 128'(0));
    chk({tag, " in_ready cmp"}, 128'(in_ready), 128'(0));
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, " ovalid shift"}, 128'(out_valid), 128'(0));
    @(negedge clk);
    chk({tag, " ovalid hold"}, 128'(out_valid), 128'(1));
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 128'(1), 128'(0));
      want = '0;
    end else begin
      want = sb.pop_front();
    end
    chk({tag, " result"}, 128'(observed()), 128'(want));
    for (int i = 0; i < stall_n; i++) begin
      @(negedge clk);
      chk({tag, " stall result"}, 128'(observed()), 128'(want));
      chk({tag, " stall ovalid"}, 128'(out_valid), 128'(1));
      chk({tag, " stall in_ready"}, 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " ovalid drop"}, 128'(out_valid), 128'(0));
    chk({tag, " in_ready back"}, 128'(in_ready), 128'(1));
  endtask

  initial begin
    logic [31:0] rx, ry;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset ovalid", 128'(out_valid), 128'(0));
    chk("reset in_ready", 128'(in_ready), 128'(1));
    chk("reset outputs", 128'(observed()), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    run_op("one_half", 32'h3F800000, 32'h3F000000,
           '{8'h7F, 32'h80000000, 32'h40000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 0);
    run_op("swap_b", 32'h3F000000, 32'h40000000,
           '{8'h80, 32'h80000000, 32'h20000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}, 0);
    run_op("diff24", 32'h4B800000, 32'h3F800001,
           '{8'h97, 32'h80000000, 32'h00000080, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}, 0);
    run_op("diff127", 32'h7F000000, 32'h3F800000,
           '{8'hFE, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}, 0);
    run_op("stall5", 32'hC0400000, 32'h3E800000, model(32'hC0400000, 32'h3E800000), 5);
    run_op("tie", 32'h41200000, 32'hC1200000, model(32'h41200000, 32'hC1200000), 0);
    run_op("denorm", 32'h00000003, 32'h00400000, model(32'h00000003, 32'h00400000), 0);
    run_op("norm_den", 32'h00800000, 32'h807FFFFF, model(32'h00800000, 32'h807FFFFF), 0);
    run_op("inf", 32'h7F800000, 32'h3F800000, model(32'h7F800000, 32'h3F800000), 1);
    run_op("diff31", 32'h4F000000, 32'h3F800001, model(32'h4F000000, 32'h3F800001), 0);
    run_op("diff32", 32'h4F800000, 32'h3F800001, model(32'h4F800000, 32'h3F800001), 0);
    run_op("zeros", 32'h00000000, 32'h80000000, model(32'h00000000, 32'h80000000), 0);
    for (int k = 0; k < 20; k++) begin
      rx = $urandom;
      ry = (k % 2 == 0) ? $urandom : {rx[31:30], 6'(rx[28:23] + 6'($urandom_range(0, 40))), 23'($urandom)};
      run_op("random", rx, ry, model(rx, ry), k % 3);
    end

    // Reset while the operation sits in SHIFT; nothing may come out afterwards.
    a = 32'h40000000; b = 32'h3F800000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst ovalid", 128'(out_valid), 128'(0));
    chk("midrst in_ready", 128'(in_ready), 128'(1));
    chk("midrst outputs", 128'(observed()), 128'(0));
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("midrst no result", 128'(out_valid), 128'(0));
    end
    out_ready = 1'b0;

    run_op("after_rst", 32'h3F800000, 32'h3F000000,
           '{8'h7F, 32'h80000000, 32'h40000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 0);

    chk("scoreboard drained", 128'(sb.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_align_ctrl.md
FP_ALIGN_CTRL -- requirements
Module: fp_align_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the operand and aligned-mantissa width.
REQ-002 SHALL have parameter SELECT_WIDTH, default 5, giving the shifter shift-amount width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, operand pair a/b present.
REQ-006 SHALL have port in_ready, output, 1, block accepts a/b.
REQ-007 SHALL have ports a and b, input, 32 each, IEEE754 single operands.
REQ-008 SHALL have port out_valid, output, 1, aligned result present.
REQ-009 SHALL have port out_ready, input, 1, consumer takes result.
REQ-010 SHALL have port exp_out, output, 8, the larger effective exponent.
REQ-011 SHALL have port man_big, output, 32, the larger operand's mantissa as {hidden, frac[22:0], 8'b0}.
REQ-012 SHALL have port man_small, output, 32, the smaller operand's mantissa in the same format, right-shifted by the exponent difference.
REQ-013 SHALL have ports sign_big and sign_small, output, 1 each, the operand signs after ordering.
REQ-014 SHALL have ports swap, sticky and special, output, 1 each: swap=b larger, sticky=OR of bits shifted out, special=either exponent 255.

Function
REQ-015 SHALL implement FSM IDLE->CMP->SHIFT->HOLD->IDLE; in_ready=1 only in IDLE.
REQ-016 SHALL capture a/b in IDLE on in_valid&in_ready and move to CMP.
REQ-017 SHALL in CMP define hidden=(exp!=0) and eff_exp=(exp==0)?1:exp, make big the operand with larger {eff_exp,frac}, choose a on tie (swap=0), register diff=eff_exp_big-eff_exp_small, and move to SHIFT.
REQ-018 SHALL in SHIFT drive shift_num=diff[4:0] to a 32-bit logical right shifter whose input is the small mantissa, register all outputs, and move to HOLD.
REQ-019 SHALL, when diff>31, force man_small=0 and sticky=|small mantissa; otherwise sticky=OR of the low diff bits of the small mantissa.
REQ-020 SHALL assert out_valid only in HOLD and keep all outputs stable while out_valid=1 and out_ready=0.
REQ-021 SHALL leave HOLD for IDLE on out_ready=1; out_valid then falls on the next cycle.
REQ-022 SHALL assert out_valid exactly 3 cycles after the accepting edge, giving a peak throughput of one operation per 4 cycles.
REQ-023 SHALL, when special=1, still perform the alignment unchanged; NaN/Inf interpretation belongs downstream.
REQ-024 SHALL ignore in_valid outside IDLE; a and b are not sampled.

Reset
REQ-025 SHALL, on rst=1 at an edge, go to IDLE from any state, including mid-operation, and discard the in-flight operation.
REQ-026 SHALL reset out_valid=0, in_ready=1 and all data/flag outputs (exp_out, man_big, man_small, signs, swap, sticky, special) to 0.

Structure
REQ-027 SHALL take the FSM state encoding, mantissa field layout constants (hidden bit 31, guard pad 8) and the exponent constants 0/255 from shared package fp_pkg.
REQ-028 SHALL instantiate the existing SHIFT_RIGHT (DATA_WIDTH=32, SELECT_WIDTH=5) once as the only sub-module; sticky masking is in this block.

Verification
REQ-029 SHALL cover a=0x3F800000, b=0x3F000000 -> after 3 cycles exp_out=0x7F, man_big=0x80000000, man_small=0x40000000, swap=0, sticky=0.
REQ-030 SHALL cover a=0x3F000000, b=0x40000000 -> swap=1, exp_out=0x80, man_small=0x20000000, sign_big=0.
REQ-031 SHALL cover a=0x4B800000, b=0x3F800001 (diff 24) -> man_small=0x00000080, sticky=1.
REQ-032 SHALL cover a=0x7F000000, b=0x3F800000 (diff 127) -> man_small=0, sticky=1, special=0.
REQ-033 SHALL cover out_ready held 0 for 5 cycles in HOLD -> outputs unchanged and in_ready=0; then out_ready=1 -> IDLE and in_ready=1 on the next cycle.
REQ-034 SHALL cover rst=1 during SHIFT -> next cycle IDLE, out_valid=0, all outputs 0, and no result emitted.
